// File: rtl/bus_ep_pkg.sv
// Shared definitions for the bus endpoint: address width, broadcast ID and
// the destination-field extractor used by the RTL and by checkers.
package bus_ep_pkg;

   localparam int          ADDR_W       = 8;
   localparam logic [7:0]  BROADCAST_ID = 8'hFF;
   localparam int          PKT_MAX_W    = 64;

   // Packets are zero-extended to PKT_MAX_W; w is the real packet width.
   function automatic logic [ADDR_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned          w);
      return ADDR_W'(pkt >> (w - ADDR_W));
   endfunction

endpackage

// File: rtl/ep_fifo.sv
// Show-ahead synchronous FIFO. Pointers wrap modulo depth; occupancy is kept
// in a separate counter so full (count==depth) and empty (count==0) are exact.
module ep_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_i,
   input  logic [width-1:0]         wr_data_i,
   input  logic                     rd_i,
   output logic [width-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(depth):0]   count_o
);
   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rd_ok, wr_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(depth));
   assign count_o = count_q;

   // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
   assign rd_ok = rd_i && !empty_o;
   assign wr_ok = wr_i && (!full_o || rd_ok);

   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/bus_endpoint.sv
// Device-side bus terminal: TX FIFO drained by the bus, RX FIFO filled by
// address-filtered bus pushes, plus registered drop / pop-error pulses.
module bus_endpoint
   import bus_ep_pkg::*;
#(
   parameter int          pckg_sz   = 16,
   parameter int          depth     = 8,
   parameter logic [7:0]  id        = 8'd0,
   parameter logic [7:0]  broadcast = BROADCAST_ID
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     pndng,
   output logic [pckg_sz-1:0]       D_pop,
   input  logic                     pop,
   input  logic                     push,
   input  logic [pckg_sz-1:0]       D_push,
   input  logic                     tx_valid,
   input  logic [pckg_sz-1:0]       tx_data,
   output logic                     tx_ready,
   output logic                     rx_valid,
   output logic [pckg_sz-1:0]       rx_data,
   input  logic                     rx_ready,
   output logic [$clog2(depth):0]   tx_count,
   output logic [$clog2(depth):0]   rx_count,
   output logic                     rx_drop,
   output logic                     pop_err
);
   logic                 tx_full, tx_empty, rx_full, rx_empty;
   logic                 tx_wr, rx_accept, rx_rd_ok;
   logic [PKT_MAX_W-1:0] push_ext;
   logic [ADDR_W-1:0]    push_dest;
   logic                 rx_drop_q, rx_drop_d, pop_err_q, pop_err_d;

   assign push_ext  = PKT_MAX_W'(D_push);
   assign push_dest = dest_of(push_ext, pckg_sz);
   assign rx_accept = push && ((push_dest == id) || (push_dest == broadcast));
   assign rx_rd_ok  = rx_ready && !rx_empty;

   // TX writes are gated by tx_ready so a user stalled on full never double-writes.
   assign tx_wr = tx_valid && !tx_full;

   assign rx_drop_d = rx_accept && rx_full && !rx_rd_ok;
   assign pop_err_d = pop && tx_empty;

   ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_i      (tx_wr),
      .wr_data_i (tx_data),
      .rd_i      (pop),
      .rd_data_o (D_pop),
      .full_o    (tx_full),
      .empty_o   (tx_empty),
      .count_o   (tx_count)
   );

   ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_i      (rx_accept),
      .wr_data_i (D_push),
      .rd_i      (rx_ready),
      .rd_data_o (rx_data),
      .full_o    (rx_full),
      .empty_o   (rx_empty),
      .count_o   (rx_count)
   );

   assign pndng    = !tx_empty;
   assign tx_ready = !tx_full;
   assign rx_valid = !rx_empty;
   assign rx_drop  = rx_drop_q;
   assign pop_err  = pop_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_drop_q <= 1'b0;
         pop_err_q <= 1'b0;
      end else begin
         rx_drop_q <= rx_drop_d;
         pop_err_q <= pop_err_d;
      end
   end

endmodule
